// File: rtl/ahb_arbiter_param.sv
// Parametrised AHB arbiter: fixed-priority or round-robin, lock hold, SPLIT masking, default master.
// Optional starvation promotion is compiled in when ARB_STARVE_PROTECT_EN is defined.
module ahb_arbiter_param #(
    parameter int NUM_MASTERS    = 16,
    parameter int MW             = $clog2(NUM_MASTERS),
    parameter int DEFAULT_MASTER = 0,
    parameter int RR_MODE        = 1,
    parameter int STARVE_LIMIT   = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQx,
    input  logic [NUM_MASTERS-1:0] HLOCKx,
    input  logic [NUM_MASTERS-1:0] HSPLIT,
    input  logic                   HREADY,
    input  logic [1:0]             HRESP,
    output logic [NUM_MASTERS-1:0] HGRANTx,
    output logic [MW-1:0]          HMASTER,
    output logic                   HMASTLOCK
);

    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MW+1:0]          NM_W          = (MW+2)'(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 16 || DEFAULT_MASTER < 0 ||
        DEFAULT_MASTER >= NUM_MASTERS || STARVE_LIMIT < 1) begin : g_badParam
        $error("ahb_arbiter_param: illegal parameter combination");
    end

    // Returns {found, index} of the lowest set bit.
    function automatic logic [MW:0] lowestSet(input logic [NUM_MASTERS-1:0] vec);
        logic [MW:0] res;
        res = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (vec[i]) res = {1'b1, MW'(i)};
        end
        return res;
    endfunction

    logic [NUM_MASTERS-1:0]   r_grant;
    logic [NUM_MASTERS-1:0]   r_splitMask;
    logic [MW-1:0]            r_master;
    logic                     r_mastLock;

    logic [NUM_MASTERS-1:0]   w_eligible;
    logic [2*NUM_MASTERS-1:0] w_doubled;
    logic [NUM_MASTERS-1:0]   w_rotated;
    logic [NUM_MASTERS-1:0]   w_nextGrant;
    logic [NUM_MASTERS-1:0]   w_splitSet;
    logic [MW-1:0]            w_grantIdx;
    logic [MW-1:0]            w_nextIdx;
    logic [MW-1:0]            w_rrIdx;
    logic [MW+1:0]            w_rrSum;
    logic [MW:0]              w_fixedPick;
    logic [MW:0]              w_rrPick;
    logic                     w_lockHold;

    assign w_eligible = HBUSREQx & ~r_splitMask;
    assign w_doubled  = {w_eligible, w_eligible};

    always_comb begin
        w_grantIdx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) w_grantIdx = MW'(i);
        end
    end

    assign w_lockHold  = HLOCKx[w_grantIdx] & HBUSREQx[w_grantIdx];
    assign w_fixedPick = lowestSet(w_eligible);

    // Rotate so bit 0 is the master after the last grantee; a shift of NUM_MASTERS wraps to master 0.
    assign w_rotated = NUM_MASTERS'(w_doubled >> (w_grantIdx + 1));
    assign w_rrPick  = lowestSet(w_rotated);
    assign w_rrSum   = {2'b00, w_grantIdx} + (MW+2)'(1) + {2'b00, w_rrPick[MW-1:0]};
    assign w_rrIdx   = (w_rrSum >= NM_W) ? MW'(w_rrSum - NM_W) : MW'(w_rrSum);

`ifdef ARB_STARVE_PROTECT_EN
    localparam int            CW      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_W = CW'(STARVE_LIMIT);

    logic [CW-1:0]          r_waitCnt [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] w_promoted;
    logic [MW:0]            w_promPick;

    always_comb begin
        w_promoted = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_promoted[i] = w_eligible[i] && (r_waitCnt[i] == LIMIT_W);
        end
    end

    assign w_promPick = lowestSet(w_promoted);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < NUM_MASTERS; i++) r_waitCnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!HBUSREQx[i] || (HREADY && w_nextGrant[i])) begin
                    r_waitCnt[i] <= '0;
                end else if (HREADY && w_eligible[i] && r_waitCnt[i] != LIMIT_W) begin
                    r_waitCnt[i] <= r_waitCnt[i] + 1'b1;
                end
            end
        end
    end
`endif

    // Lock hold beats everything; with nobody eligible the default master idles on the bus.
    always_comb begin
        w_nextIdx = MW'(DEFAULT_MASTER);
        if (w_lockHold) begin
            w_nextIdx = w_grantIdx;
        end
`ifdef ARB_STARVE_PROTECT_EN
        else if (w_promPick[MW]) begin
            w_nextIdx = w_promPick[MW-1:0];
        end
`endif
        else if (RR_MODE != 0 && w_rrPick[MW]) begin
            w_nextIdx = w_rrIdx;
        end else if (RR_MODE == 0 && w_fixedPick[MW]) begin
            w_nextIdx = w_fixedPick[MW-1:0];
        end
    end

    always_comb begin
        w_nextGrant = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_nextGrant[i] = (w_nextIdx == MW'(i));
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_grant    <= DEFAULT_GRANT;
            r_master   <= MW'(DEFAULT_MASTER);
            r_mastLock <= 1'b0;
        end else if (HREADY) begin
            r_grant    <= w_nextGrant;
            r_master   <= w_grantIdx;
            r_mastLock <= HLOCKx[w_grantIdx];
        end
    end

    // OR-ing the set after the clear lets a same-cycle SPLIT win over HSPLIT.
    assign w_splitSet = (HREADY && HRESP == 2'b11) ? (NUM_MASTERS'(1) << r_master) : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_splitMask <= '0;
        end else begin
            r_splitMask <= (r_splitMask & ~HSPLIT) | w_splitSet;
        end
    end

    assign HGRANTx   = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastLock;

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Testbench for ahb_arbiter_param: a round-robin and a fixed-priority instance share stimulus,
// checked against hand-computed vectors and a behavioural reference model.
module tb_ahb_arbiter_param;

    localparam int N     = 16;
    localparam int MW    = 4;
    localparam int LIMIT = 8;
`ifdef ARB_STARVE_PROTECT_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [N-1:0]  HBUSREQx, HLOCKx, HSPLIT;
    logic          HREADY;
    logic [1:0]    HRESP;
    logic [N-1:0]  grantRr, grantFx;
    logic [MW-1:0] masterRr, masterFx;
    logic          lockRr, lockFx;

    int checks   = 0;
    int failures = 0;

    // Reference model state, index 0 = fixed priority, 1 = round robin.
    int     mGrant [2];
    int     mMaster[2];
    int     mLock  [2];
    bit [N-1:0] mSplit[2];
    int     mWait  [2][N];

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  lock;
        logic [N-1:0]  split;
        logic          ready;
        logic [1:0]    resp;
        logic [N-1:0]  gRr;
        logic [MW-1:0] mRr;
        logic          lRr;
        logic [N-1:0]  gFx;
        logic [MW-1:0] mFx;
        logic          lFx;
    } vec_t;

    vec_t vecs[23];

    always #5 HCLK = ~HCLK;

    ahb_arbiter_param #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .RR_MODE(1), .STARVE_LIMIT(LIMIT)) dutRr (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
        .HREADY(HREADY), .HRESP(HRESP), .HGRANTx(grantRr), .HMASTER(masterRr), .HMASTLOCK(lockRr)
    );

    ahb_arbiter_param #(.NUM_MASTERS(N), .DEFAULT_MASTER(0), .RR_MODE(0), .STARVE_LIMIT(LIMIT)) dutFx (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQx(HBUSREQx), .HLOCKx(HLOCKx), .HSPLIT(HSPLIT),
        .HREADY(HREADY), .HRESP(HRESP), .HGRANTx(grantFx), .HMASTER(masterFx), .HMASTLOCK(lockFx)
    );

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mGrant[m]  = 0;
            mMaster[m] = 0;
            mLock[m]   = 0;
            mSplit[m]  = '0;
            for (int i = 0; i < N; i++) mWait[m][i] = 0;
        end
    endtask

    // One rising edge of the arbiter described by its rules, for mode m.
    task automatic modelStep(input int m);
        int g, oldMaster, nxt, promo, c;
        bit found;
        bit elig[N];
        g = mGrant[m];
        oldMaster = mMaster[m];
        for (int i = 0; i < N; i++) elig[i] = HBUSREQx[i] && !mSplit[m][i];
        if (HREADY) begin
            nxt = 0;
            if (HLOCKx[g] && HBUSREQx[g]) begin
                nxt = g;
            end else begin
                promo = -1;
                if (STARVE_EN) begin
                    for (int i = N - 1; i >= 0; i--)
                        if (elig[i] && mWait[m][i] >= LIMIT) promo = i;
                end
                found = 1'b0;
                if (promo >= 0) begin
                    nxt = promo;
                end else if (m == 1) begin
                    for (int k = 1; k <= N; k++) begin
                        c = (g + k) % N;
                        if (!found && elig[c]) begin
                            nxt = c;
                            found = 1'b1;
                        end
                    end
                end else begin
                    for (int i = 0; i < N; i++) begin
                        if (!found && elig[i]) begin
                            nxt = i;
                            found = 1'b1;
                        end
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!HBUSREQx[i] || i == nxt) mWait[m][i] = 0;
                else if (elig[i] && mWait[m][i] < LIMIT) mWait[m][i]++;
            end
            mMaster[m] = g;
            mLock[m]   = HLOCKx[g];
            mGrant[m]  = nxt;
        end else begin
            for (int i = 0; i < N; i++) if (!HBUSREQx[i]) mWait[m][i] = 0;
        end
        mSplit[m] = mSplit[m] & ~HSPLIT;
        if (HREADY && HRESP == 2'b11) mSplit[m][oldMaster] = 1'b1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " rr grant"},  32'(grantRr),  32'(1) << mGrant[1]);
        checkOutput({tag, " rr master"}, 32'(masterRr), 32'(mMaster[1]));
        checkOutput({tag, " rr lock"},   32'(lockRr),   32'(mLock[1]));
        checkOutput({tag, " fx grant"},  32'(grantFx),  32'(1) << mGrant[0]);
        checkOutput({tag, " fx master"}, 32'(masterFx), 32'(mMaster[0]));
        checkOutput({tag, " fx lock"},   32'(lockFx),   32'(mLock[0]));
        checkOutput({tag, " rr onehot"}, 32'($countones(grantRr)), 32'd1);
        checkOutput({tag, " fx onehot"}, 32'($countones(grantFx)), 32'd1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " rr grant"},  32'(grantRr),  32'h0001);
        checkOutput({tag, " rr master"}, 32'(masterRr), 32'd0);
        checkOutput({tag, " rr lock"},   32'(lockRr),   32'd0);
        checkOutput({tag, " fx grant"},  32'(grantFx),  32'h0001);
        checkOutput({tag, " fx master"}, 32'(masterFx), 32'd0);
        checkOutput({tag, " fx lock"},   32'(lockFx),   32'd0);
    endtask

    // Drives one cycle of inputs, advances the model at the edge and leaves time 1 unit past it.
    task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] lock,
                                 input logic [N-1:0] split, input logic ready, input logic [1:0] resp);
        HBUSREQx = req;
        HLOCKx   = lock;
        HSPLIT   = split;
        HREADY   = ready;
        HRESP    = resp;
        @(posedge HCLK);
        modelStep(0);
        modelStep(1);
        #1;
    endtask

    initial begin
        logic [N-1:0] req;
        logic [N-1:0] lk;
        logic [N-1:0] sp;
        logic         rdy;
        logic [1:0]   rsp;
        bit           seen3;

        vecs = '{
            '{16'h0000, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0001, 4'd0, 1'b0, 16'h0001, 4'd0, 1'b0},
            '{16'h0007, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0002, 4'd0, 1'b0, 16'h0001, 4'd0, 1'b0},
            '{16'h0007, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0004, 4'd1, 1'b0, 16'h0001, 4'd0, 1'b0},
            '{16'h0007, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0001, 4'd2, 1'b0, 16'h0001, 4'd0, 1'b0},
            '{16'h0007, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0002, 4'd0, 1'b0, 16'h0001, 4'd0, 1'b0},
            '{16'h0005, 16'h0004, 16'h0000, 1'b1, 2'd0, 16'h0004, 4'd1, 1'b0, 16'h0001, 4'd0, 1'b0},
            '{16'h0005, 16'h0004, 16'h0000, 1'b1, 2'd0, 16'h0004, 4'd2, 1'b1, 16'h0001, 4'd0, 1'b0},
            '{16'h0005, 16'h0004, 16'h0000, 1'b1, 2'd0, 16'h0004, 4'd2, 1'b1, 16'h0001, 4'd0, 1'b0},
            '{16'h0001, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0004, 4'd2, 1'b1, 16'h0001, 4'd0, 1'b0},
            '{16'h0001, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0001, 4'd2, 1'b0, 16'h0001, 4'd0, 1'b0},
            '{16'h0020, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0020, 4'd0, 1'b0, 16'h0020, 4'd0, 1'b0},
            '{16'h0020, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0020, 4'd5, 1'b0, 16'h0020, 4'd5, 1'b0},
            '{16'h0020, 16'h0000, 16'h0000, 1'b0, 2'd3, 16'h0020, 4'd5, 1'b0, 16'h0020, 4'd5, 1'b0},
            '{16'h0020, 16'h0000, 16'h0000, 1'b1, 2'd3, 16'h0020, 4'd5, 1'b0, 16'h0020, 4'd5, 1'b0},
            '{16'h0020, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0001, 4'd5, 1'b0, 16'h0001, 4'd5, 1'b0},
            '{16'h0020, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0001, 4'd0, 1'b0, 16'h0001, 4'd0, 1'b0},
            '{16'h0020, 16'h0000, 16'h0020, 1'b1, 2'd0, 16'h0001, 4'd0, 1'b0, 16'h0001, 4'd0, 1'b0},
            '{16'h0020, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0020, 4'd0, 1'b0, 16'h0020, 4'd0, 1'b0},
            '{16'h00FF, 16'h00FF, 16'h0000, 1'b0, 2'd0, 16'h0020, 4'd0, 1'b0, 16'h0020, 4'd0, 1'b0},
            '{16'h1234, 16'h0000, 16'h0000, 1'b0, 2'd3, 16'h0020, 4'd0, 1'b0, 16'h0020, 4'd0, 1'b0},
            '{16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 2'd0, 16'h0020, 4'd0, 1'b0, 16'h0020, 4'd0, 1'b0},
            '{16'h0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0020, 4'd0, 1'b0, 16'h0020, 4'd0, 1'b0},
            '{16'h0020, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h0020, 4'd5, 1'b0, 16'h0020, 4'd5, 1'b0}
        };

        HRESETn  = 1'b0;
        HBUSREQx = '0;
        HLOCKx   = '0;
        HSPLIT   = '0;
        HREADY   = 1'b0;
        HRESP    = 2'd0;
        modelReset();
        repeat (2) @(posedge HCLK);
        #1;
        checkReset("reset");
        HRESETn = 1'b1;

        $display("[TB] directed vectors");
        for (int v = 0; v < 23; v++) begin
            applyStimulus(vecs[v].req, vecs[v].lock, vecs[v].split, vecs[v].ready, vecs[v].resp);
            checkOutput($sformatf("vec%0d rr grant", v),  32'(grantRr),  32'(vecs[v].gRr));
            checkOutput($sformatf("vec%0d rr master", v), 32'(masterRr), 32'(vecs[v].mRr));
            checkOutput($sformatf("vec%0d rr lock", v),   32'(lockRr),   32'(vecs[v].lRr));
            checkOutput($sformatf("vec%0d fx grant", v),  32'(grantFx),  32'(vecs[v].gFx));
            checkOutput($sformatf("vec%0d fx master", v), 32'(masterFx), 32'(vecs[v].mFx));
            checkOutput($sformatf("vec%0d fx lock", v),   32'(lockFx),   32'(vecs[v].lFx));
        end

        $display("[TB] fixed-priority starvation sequence");
        seen3 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(16'h000C, 16'h0000, 16'h0000, 1'b1, 2'd0);
            checkModel($sformatf("starve%0d", c));
            if (grantFx[3]) seen3 = 1'b1;
        end
        checkOutput("fx master3 granted", 32'(seen3), 32'(STARVE_EN));

        $display("[TB] randomized traffic");
        req = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = N'($urandom);
            lk  = N'($urandom & $urandom & $urandom);
            sp  = ($urandom_range(0, 3) == 0) ? N'($urandom & $urandom) : '0;
            rdy = ($urandom_range(0, 3) != 0);
            rsp = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            applyStimulus(req, lk, sp, rdy, rsp);
            checkModel($sformatf("rand%0d", c));
        end

        $display("[TB] reset mid-burst");
        applyStimulus(16'hFFF0, 16'h0000, 16'h0000, 1'b1, 2'd3);
        applyStimulus(16'hFFF0, 16'h00F0, 16'h0000, 1'b1, 2'd3);
        #3;
        HRESETn = 1'b0;
        #1;
        checkReset("midReset");
        modelReset();
        @(negedge HCLK);
        HRESETn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if ($urandom_range(0, 2) == 0) req = N'($urandom);
            rsp = ($urandom_range(0, 5) == 0) ? 2'd3 : 2'd0;
            applyStimulus(req, '0, '0, 1'b1, rsp);
            checkModel($sformatf("post%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_param.md
Name: ahb_arbiter_param

Overview:
Parametrised AHB bus arbiter; successor to the fixed 16-master arbiter. Supports configurable master count, fixed-priority or round-robin mode, a default master, locked transfers and SPLIT masking. Sits between the masters' request/lock lines and the address/data muxes; drives HGRANTx, HMASTER and HMASTLOCK.

Parameters:
NUM_MASTERS, 16, number of masters (2..16)
MW, $clog2(NUM_MASTERS), HMASTER width (derived, do not override)
DEFAULT_MASTER, 0, master granted when no valid request
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)
STARVE_LIMIT, 8, wait-cycle threshold; used only with the optional feature

Ports:
HCLK  in  1  bus clock, all state on rising edge
HRESETn  in  1  asynchronous active-low reset
HBUSREQx  in  NUM_MASTERS  per-master bus request
HLOCKx  in  NUM_MASTERS  per-master locked-transfer request
HSPLIT  in  NUM_MASTERS  slave split-resume, one bit per master, single-cycle pulse
HREADY  in  1  transfer complete; arbitration advances only when high
HRESP  in  2  slave response; 2'b11 = SPLIT
HGRANTx  out  NUM_MASTERS  one-hot grant, registered
HMASTER  out  MW  index of current address-phase owner, registered
HMASTLOCK  out  1  current transfer is locked, registered

Behaviour:
- Reset (async, HRESETn=0): HGRANTx = one-hot DEFAULT_MASTER; HMASTER = DEFAULT_MASTER; HMASTLOCK = 0; split_mask = 0; RR pointer = DEFAULT_MASTER.
- HGRANTx always exactly one-hot, never all-zero, including reset.
- eligible[i] = HBUSREQx[i] & ~split_mask[i].
- Arbitration computed combinationally each cycle. Registered into HGRANTx only on a rising edge with HREADY=1. With HREADY=0, HGRANTx, HMASTER and HMASTLOCK hold.
- Lock hold: if the current grantee has HLOCKx=1 and HBUSREQx=1, its grant is kept regardless of other requests.
- Fixed mode: lowest-index eligible master wins.
- RR mode: search starts at (last grantee + 1) mod NUM_MASTERS and wraps. RR pointer updates whenever a new grant registers.
- Current grantee still requesting and not locked: in RR mode it is re-arbitrated like any other master.
- No eligible request: grant DEFAULT_MASTER, even if that master is split-masked (acts as idle owner).
- Address-phase handover: on a rising edge with HREADY=1, HMASTER <= index of HGRANTx (pre-update value) and HMASTLOCK <= HLOCKx[that index]. HMASTER therefore lags HGRANTx by one HREADY cycle.
- SPLIT: on a rising edge with HREADY=1 and HRESP=2'b11, set split_mask[HMASTER].
- HSPLIT[i]=1 clears split_mask[i] on the next edge.
- Set and clear of the same bit in the same cycle: set wins.
- A split master's request is ignored until its mask bit clears. It re-enters arbitration the cycle after the clear.
- HSPLIT bits at or above NUM_MASTERS are not present; there are no out-of-range indices.
- Reset asserted mid-transfer: immediate return to reset values; no pending state survives.

Optional Feature:
Macro: ARB_STARVE_PROTECT_EN.
- Defined:
  - Each master has a wait counter of width $clog2(STARVE_LIMIT+1). It increments each HREADY=1 edge while eligible and not granted, saturates at STARVE_LIMIT, and clears when the master is granted or deasserts HBUSREQx.
  - A master at STARVE_LIMIT is promoted above all non-promoted masters in either mode. Lowest index wins among promoted masters.
  - Lock hold still overrides promotion.
- Undefined: no counters; pure fixed-priority or RR arbitration as configured. Port list is identical in both builds.

Test Plan:
- Reset then idle, no requests -> HGRANTx=16'h0001, HMASTER=0, HMASTLOCK=0; stays one-hot every cycle.
- RR_MODE=1, HBUSREQx=16'h0007 held, HREADY=1 -> grants rotate 0x0002, 0x0004, 0x0001, 0x0002; HMASTER follows one cycle later.
- RR_MODE=0, HBUSREQx=16'h000C -> HGRANTx=0x0004 persists; master 3 never granted. Rerun with ARB_STARVE_PROTECT_EN and STARVE_LIMIT=8 -> master 3 granted within 9 HREADY cycles.
- Master 2 holds HLOCKx[2]=1 and HBUSREQx[2]=1 while master 0 requests -> HGRANTx stays 0x0004 and HMASTLOCK=1 until HLOCKx[2] drops; then 0x0001 is granted.
- HMASTER=5, HRESP=2'b11 with HREADY 0 then 1 -> master 5 is ignored despite HBUSREQx[5]=1. Pulse HSPLIT[5] -> master 5 is granted again on the next arbitration.
- HREADY held 0 for 4 cycles while requests change -> HGRANTx, HMASTER and HMASTLOCK unchanged. HRESETn pulsed low mid-burst -> all outputs return to reset values immediately.
